conv_patch_sched: RTL and testbench
===================================

Name: conv_patch_sched

Overview:
Sequencer placed in front of the conv tile engine.
- Accepts input patches over a valid/ready stream and holds a shadow kernel register.
- For each patch: drives conv's reset pulse, presents kernel and patch, waits for finalCompute, then returns the tile result on a valid/ready output stream tagged with a patch index.
- Replaces bench-style fixed-delay sequencing with a hardware FSM.

Parameters:
KERNEL_SIZE, 3, kernel edge length
INPUT_TILE_SIZE, 3, input patch edge length
INPUT_DATA_WIDTH, 8, signed pixel width
KERNEL_DATA_WIDTH, 8, signed kernel coefficient width
CHANNELS, 3, channels per patch
OUTPUT_BIT_WIDTH, INPUT_DATA_WIDTH+KERNEL_DATA_WIDTH+8, width of one result element
OUTPUT_TILE_SIZE, INPUT_TILE_SIZE-KERNEL_SIZE+1, result tile edge length
CONV_RST_CYCLES, 4, cycles conv_reset is held high per patch (1..255)
TIMEOUT_CYCLES, 1024, RUN-state watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_kernel_we  in  1  write strobe for the shadow kernel
cfg_kernel  in  KS*KS*KDW*CH  kernel value to write
in_valid  in  1  input patch valid
in_ready  out  1  scheduler can accept a patch
in_data  in  ITS*ITS*IDW*CH  patch data, channel 0 in the LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  OTS*OTS*OBW  registered conv result
out_patch_idx  out  32  1-based index of the patch in out_data
conv_reset  out  1  active-high reset to conv
conv_kernel  out  KS*KS*KDW*CH  active kernel, held stable while busy
conv_inpData  out  ITS*ITS*IDW*CH  latched patch, held stable while busy
conv_outData  in  OTS*OTS*OBW  conv result
conv_finalCompute  in  1  conv done flag
busy  out  1  high in any state except IDLE
err_timeout  out  1  sticky watchdog error (optional feature only)

Behaviour:
- Reset values:
  - State = IDLE; in_ready = 1; out_valid = 0.
  - out_data, conv_kernel, conv_inpData, shadow kernel = 0.
  - out_patch_idx = 0; internal index counter = 1.
  - conv_reset = 1; busy = 0; err_timeout = 0.
- conv_reset is 1 in IDLE and RST, and 0 in RUN and OUT. This keeps conv cleared between patches.
- Shadow kernel: loaded on any cycle with cfg_kernel_we = 1, in any state.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_data into conv_inpData and copy the shadow into conv_kernel, then go to RST.
  - If cfg_kernel_we and the accept occur in the same cycle, the new cfg_kernel value goes directly to conv_kernel for that patch.
- RST:
  - Hold for exactly CONV_RST_CYCLES cycles (down-counter), then go to RUN.
  - in_ready = 0 in RST and in every state other than IDLE.
- RUN:
  - conv_finalCompute is sampled only in this state. It is ignored in all other states, so a stale flag is never seen.
  - On the first cycle it is 1: register conv_outData into out_data, load out_patch_idx from the counter, set out_valid = 1, go to OUT.
- OUT:
  - out_data and out_patch_idx stay stable while out_valid = 1 and out_ready = 0.
  - On out_ready: out_valid = 0, counter increments (wraps 0xFFFFFFFF -> 0), go to IDLE.
  - in_ready rises the cycle after the handshake.
- Throughput: one patch per (1 + CONV_RST_CYCLES + conv latency + 1) cycles at minimum. There is no overlap between patches.
- Ports that take no action (in_data while not in IDLE, out_ready while out_valid = 0) are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all reset values, and any in-flight patch is discarded.

Optional Feature:
Macro CONV_SCHED_TIMEOUT_EN.
- Defined:
  - RUN counts cycles. If TIMEOUT_CYCLES elapse without finalCompute, set err_timeout = 1 (sticky until reset).
  - Then emit out_data = 0 with the current index through OUT, so the stream never stalls.
- Not defined:
  - No counter and no timeout; RUN waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Write kernel {1,2,1,2,4,2,1,2,1} to all 3 channels; send one patch of all 1s in every channel; out_ready = 1 -> out_data = 24'h000030, out_patch_idx = 1, conv_reset high for exactly 4 cycles before RUN.
- Send 3 back-to-back patches (R/G/B all 2, then all -1, then all 0) -> outputs 0x000060, 0xFFFFD0, 0x000000 with idx 1, 2, 3; in_ready low while busy.
- Hold out_ready = 0 for 20 cycles after out_valid -> out_data and idx stable, in_ready stays 0, no second patch accepted; release -> handshake completes, in_ready = 1 the next cycle.
- Assert cfg_kernel_we with all-zero kernel during RUN of patch 1 -> patch 1 result still uses the old kernel; patch 2 result = 0.
- Pull reset low in the middle of RUN -> next cycle state IDLE, out_valid = 0, conv_reset = 1, counter = 1; the following patch is reported as idx 1.
- With CONV_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16, hold conv_finalCompute = 0 -> after 16 RUN cycles err_timeout = 1 and out_valid = 1 with out_data = 0.

Source files
------------

// File: rtl/conv_patch_sched.sv
`default_nettype none
//==============================================================================
// Module   : conv_patch_sched
// Brief    : One-patch-at-a-time sequencer for the conv tile engine. It pulses
//            conv_reset, presents the kernel and patch, waits for
//            finalCompute and returns the result with a patch index.
//            Optional macro CONV_SCHED_TIMEOUT_EN adds a sticky RUN watchdog.
// Revision : 1.0 - initial release
//==============================================================================
module conv_patch_sched #(
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_TILE_SIZE   = 3,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int CHANNELS          = 3,
    parameter int OUTPUT_BIT_WIDTH  = INPUT_DATA_WIDTH + KERNEL_DATA_WIDTH + 8,
    parameter int OUTPUT_TILE_SIZE  = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
    parameter int CONV_RST_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic                                                         cfg_kernel_we,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH*CHANNELS-1:0]       cfg_kernel,
    input  logic                                                         in_valid,
    output logic                                                         in_ready,
    input  logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH*CHANNELS-1:0] in_data,
    output logic                                                         out_valid,
    input  logic                                                         out_ready,
    output logic [OUTPUT_TILE_SIZE*OUTPUT_TILE_SIZE*OUTPUT_BIT_WIDTH-1:0]       out_data,
    output logic [31:0]                                                  out_patch_idx,
    output logic                                                         conv_reset,
    output logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH*CHANNELS-1:0]       conv_kernel,
    output logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH*CHANNELS-1:0] conv_inpData,
    input  logic [OUTPUT_TILE_SIZE*OUTPUT_TILE_SIZE*OUTPUT_BIT_WIDTH-1:0]       conv_outData,
    input  logic                                                         conv_finalCompute,
    output logic                                                         busy,
    output logic                                                         err_timeout
);

    localparam int c_KERN_W = KERNEL_SIZE * KERNEL_SIZE * KERNEL_DATA_WIDTH * CHANNELS;
    localparam int c_IN_W   = INPUT_TILE_SIZE * INPUT_TILE_SIZE * INPUT_DATA_WIDTH * CHANNELS;
    localparam int c_OUT_W  = OUTPUT_TILE_SIZE * OUTPUT_TILE_SIZE * OUTPUT_BIT_WIDTH;
    localparam logic [7:0] c_RST_LAST = 8'(CONV_RST_CYCLES - 1);

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_KERN_W-1:0]   r_shadow;
    logic [c_KERN_W-1:0]   r_conv_kernel;
    logic [c_IN_W-1:0]     r_conv_inp;
    logic [c_OUT_W-1:0]    r_out_data;
    logic [31:0]           r_out_idx;
    logic [31:0]           r_idx;
    logic [7:0]            r_rst_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_conv_reset;
`ifdef CONV_SCHED_TIMEOUT_EN
    logic [c_TO_W-1:0]     r_to_cnt;
    logic                  r_err;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shadow      <= '0;
            r_conv_kernel <= '0;
            r_conv_inp    <= '0;
            r_out_data    <= '0;
            r_out_idx     <= 32'd0;
            r_idx         <= 32'd1;
            r_rst_cnt     <= 8'd0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_conv_reset  <= 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            if (cfg_kernel_we) begin
                r_shadow <= cfg_kernel;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_conv_inp    <= in_data;
                        // A kernel written in the accept cycle applies to this patch.
                        r_conv_kernel <= cfg_kernel_we ? cfg_kernel : r_shadow;
                        r_rst_cnt     <= c_RST_LAST;
                        r_in_ready    <= 1'b0;
                        r_state       <= S_RST;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == 8'd0) begin
                        r_conv_reset <= 1'b0;
                        r_state      <= S_RUN;
`ifdef CONV_SCHED_TIMEOUT_EN
                        r_to_cnt     <= '0;
`endif
                    end else begin
                        r_rst_cnt <= r_rst_cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (conv_finalCompute) begin
                        r_out_data  <= conv_outData;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
`ifdef CONV_SCHED_TIMEOUT_EN
                    // A hung engine still yields a zero result so the stream keeps moving.
                    else if (r_to_cnt == c_TO_LAST) begin
                        r_err       <= 1'b1;
                        r_out_data  <= '0;
                        r_out_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_idx        <= r_idx + 32'd1;
                        r_in_ready   <= 1'b1;
                        r_conv_reset <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_patch_idx = r_out_idx;
    assign conv_reset    = r_conv_reset;
    assign conv_kernel   = r_conv_kernel;
    assign conv_inpData  = r_conv_inp;
    assign busy          = (r_state != S_IDLE);

`ifdef CONV_SCHED_TIMEOUT_EN
    assign err_timeout = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign err_timeout      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_patch_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_conv_patch_sched
// Brief    : Bench for conv_patch_sched with a behavioural conv engine model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_conv_patch_sched;

    localparam int KS   = 3;
    localparam int ITS  = 3;
    localparam int IDW  = 8;
    localparam int KDW  = 8;
    localparam int CH   = 3;
    localparam int OBW  = IDW + KDW + 8;
    localparam int OTS  = ITS - KS + 1;
    localparam int RSTC = 4;
    localparam int TO   = 16;
    localparam int KW   = KS * KS * KDW * CH;
    localparam int IW   = ITS * ITS * IDW * CH;
    localparam int OW   = OTS * OTS * OBW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_kernel_we = 1'b0;
    logic [KW-1:0] cfg_kernel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [31:0]   out_patch_idx;
    logic          conv_reset;
    logic [KW-1:0] conv_kernel;
    logic [IW-1:0] conv_inpData;
    logic [OW-1:0] conv_outData = '0;
    logic          conv_finalCompute = 1'b0;
    logic          busy;
    logic          err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int g_lat = 2;
    bit g_hang = 0;
    bit g_stale = 0;
    int cm_cnt = 0;
    logic [KW-1:0] exp_shadow = '0;
    int exp_idx = 1;

    always #5 clk = ~clk;

    conv_patch_sched #(
        .KERNEL_SIZE(KS), .INPUT_TILE_SIZE(ITS), .INPUT_DATA_WIDTH(IDW),
        .KERNEL_DATA_WIDTH(KDW), .CHANNELS(CH), .OUTPUT_BIT_WIDTH(OBW),
        .OUTPUT_TILE_SIZE(OTS), .CONV_RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .cfg_kernel_we(cfg_kernel_we), .cfg_kernel(cfg_kernel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_patch_idx(out_patch_idx), .conv_reset(conv_reset), .conv_kernel(conv_kernel),
        .conv_inpData(conv_inpData), .conv_outData(conv_outData),
        .conv_finalCompute(conv_finalCompute), .busy(busy), .err_timeout(err_timeout)
    );

    // Reference convolution: valid-mode 2D conv summed over all channels.
    function automatic logic [OW-1:0] conv_ref(input logic [KW-1:0] k, input logic [IW-1:0] d);
        logic [OW-1:0] r;
        logic signed [KDW-1:0] kv;
        logic signed [IDW-1:0] dv;
        longint acc;
        r = '0;
        for (int oy = 0; oy < OTS; oy++) begin
            for (int ox = 0; ox < OTS; ox++) begin
                acc = 0;
                for (int c = 0; c < CH; c++)
                    for (int ky = 0; ky < KS; ky++)
                        for (int kx = 0; kx < KS; kx++) begin
                            kv = k[(c*KS*KS + ky*KS + kx)*KDW +: KDW];
                            dv = d[(c*ITS*ITS + (oy+ky)*ITS + ox + kx)*IDW +: IDW];
                            acc += longint'(kv) * longint'(dv);
                        end
                r[(oy*OTS + ox)*OBW +: OBW] = acc[OBW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] fill_patch(input int v);
        logic [IW-1:0] p;
        for (int i = 0; i < ITS*ITS*CH; i++) p[i*IDW +: IDW] = v[IDW-1:0];
        return p;
    endfunction

    function automatic logic [KW-1:0] kern_from9(input int kc[9]);
        logic [KW-1:0] k;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < KS*KS; i++) k[(c*KS*KS + i)*KDW +: KDW] = kc[i % 9][KDW-1:0];
        return k;
    endfunction

    function automatic logic [IW-1:0] rand_patch();
        logic [IW-1:0] p;
        for (int i = 0; i < IW; i++) p[i] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic logic [KW-1:0] rand_kernel();
        logic [KW-1:0] k;
        for (int i = 0; i < KW; i++) k[i] = 1'($urandom_range(0, 1));
        return k;
    endfunction

    // Conv engine model: counts latency after conv_reset drops, then holds done.
    always @(posedge clk) begin
        if (!reset || g_hang) begin
            cm_cnt            <= 0;
            conv_finalCompute <= 1'b0;
            conv_outData      <= OW'($urandom);
        end else if (conv_reset) begin
            cm_cnt            <= 0;
            conv_finalCompute <= g_stale && in_ready;
            conv_outData      <= OW'($urandom);
        end else if (cm_cnt >= g_lat) begin
            conv_finalCompute <= 1'b1;
            conv_outData      <= conv_ref(conv_kernel, conv_inpData);
        end else begin
            cm_cnt            <= cm_cnt + 1;
            conv_finalCompute <= 1'b0;
            conv_outData      <= OW'($urandom);
        end
    end

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_kernel_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_shadow = '0;
        exp_idx = 1;
        @(negedge clk);
    endtask

    task automatic write_kernel(input logic [KW-1:0] k);
        cfg_kernel = k; cfg_kernel_we = 1'b1; exp_shadow = k;
        @(negedge clk);
        cfg_kernel_we = 1'b0;
    endtask

    // Presents a patch, optionally with a same-cycle kernel write; returns at the first RUN cycle.
    task automatic accept_patch(input logic [IW-1:0] d, input bit with_cfg, input logic [KW-1:0] k,
                                output int rst_cyc, output bit ok);
        int n;
        in_data = d; in_valid = 1'b1; rst_cyc = -1; ok = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (in_ready) begin
            if (with_cfg) begin cfg_kernel = k; cfg_kernel_we = 1'b1; exp_shadow = k; end
            @(negedge clk);
            cfg_kernel_we = 1'b0; in_valid = 1'b0; in_data = rand_patch();
            rst_cyc = 0;
            while (conv_reset && rst_cyc < 1000) begin rst_cyc++; @(negedge clk); end
            ok = !conv_reset;
        end
    endtask

    task automatic wait_result(output logic [OW-1:0] d, output logic [31:0] idx, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 500) begin @(negedge clk); n++; end
        ok = out_valid; d = out_data; idx = out_patch_idx;
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_idx++;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
        n_cmp++; if (conv_reset !== 1'b1 || err_timeout !== 1'b0) begin n_err++;
            $display("FAIL reset_flags: conv_reset=%b err_timeout=%b want 1/0", conv_reset, err_timeout); end
        n_cmp++; if (out_data !== '0 || out_patch_idx !== 32'd0) begin n_err++;
            $display("FAIL reset_out: data=%h idx=%0d want 0/0", out_data, out_patch_idx); end
        n_cmp++; if (conv_kernel !== '0 || conv_inpData !== '0) begin n_err++;
            $display("FAIL reset_conv_regs: kernel=%h inp=%h want 0", conv_kernel, conv_inpData); end
    endtask

    task automatic test_basic();
        int kc[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        logic [KW-1:0] k; logic [IW-1:0] p; logic [OW-1:0] d; logic [31:0] idx; int rc; bit ok;
        k = kern_from9(kc); write_kernel(k);
        p = fill_patch(1); g_lat = 3; g_stale = 0;
        accept_patch(p, 1'b0, '0, rc, ok);
        n_cmp++; if (!ok || rc != RSTC) begin n_err++;
            $display("FAIL basic_conv_reset_cycles: got %0d want %0d", rc, RSTC); end
        n_cmp++; if (conv_kernel !== k || conv_inpData !== p) begin n_err++;
            $display("FAIL basic_conv_inputs: kernel=%h inp=%h want %h / %h", conv_kernel, conv_inpData, k, p); end
        n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_err++;
            $display("FAIL basic_busy: in_ready=%b busy=%b want 0/1", in_ready, busy); end
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== OW'(48) || idx !== 32'd1) begin n_err++;
            $display("FAIL basic_result: data=%h idx=%0d valid=%b want 000030 / 1", d, idx, ok); end
        handshake(0);
    endtask

    task automatic test_back_to_back();
        int kc[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int vals[3] = '{2, -1, 0};
        logic [OW-1:0] exps[3] = '{OW'('h000060), OW'('hFFFFD0), OW'('h000000)};
        logic [OW-1:0] d; logic [31:0] idx; int rc; bit ok;
        do_reset();
        write_kernel(kern_from9(kc));
        for (int i = 0; i < 3; i++) begin
            g_lat = i;
            accept_patch(fill_patch(vals[i]), 1'b0, '0, rc, ok);
            wait_result(d, idx, ok);
            n_cmp++; if (!ok || d !== exps[i] || idx !== 32'(i + 1)) begin n_err++;
                $display("FAIL b2b_result%0d: data=%h idx=%0d want %h / %0d", i, d, idx, exps[i], i + 1); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++;
                $display("FAIL b2b_in_ready%0d: got %b want 0", i, in_ready); end
            handshake(0);
        end
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] p1, p2; logic [OW-1:0] d; logic [31:0] idx; int rc, bad; bit ok;
        write_kernel(rand_kernel());
        p1 = rand_patch(); p2 = rand_patch(); g_lat = 1;
        accept_patch(p1, 1'b0, '0, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== conv_ref(exp_shadow, p1) || idx !== 32'(exp_idx)) begin n_err++;
            $display("FAIL bp_result: data=%h idx=%0d want %h / %0d", d, idx, conv_ref(exp_shadow, p1), exp_idx); end
        in_data = p2; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_data !== d || out_patch_idx !== idx || out_valid !== 1'b1 ||
                in_ready !== 1'b0 || conv_inpData !== p1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++;
            $display("FAIL bp_hold_stable: %0d unstable cycles want 0", bad); end
        handshake(0);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        accept_patch(p2, 1'b0, '0, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== conv_ref(exp_shadow, p2) || idx !== 32'(exp_idx)) begin n_err++;
            $display("FAIL bp_second: data=%h idx=%0d want %h / %0d", d, idx, conv_ref(exp_shadow, p2), exp_idx); end
        handshake(1);
    endtask

    task automatic test_kernel_shadow();
        logic [KW-1:0] ka, kb, kuse; logic [IW-1:0] p; logic [OW-1:0] d; logic [31:0] idx; int rc; bit ok;
        ka = rand_kernel(); kb = rand_kernel();
        write_kernel(ka);
        p = rand_patch(); g_lat = 4;
        accept_patch(p, 1'b0, '0, rc, ok);
        kuse = exp_shadow;
        write_kernel('0);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== conv_ref(kuse, p)) begin n_err++;
            $display("FAIL shadow_old_kernel: data=%h want %h", d, conv_ref(kuse, p)); end
        handshake(0);
        p = rand_patch();
        accept_patch(p, 1'b0, '0, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== '0) begin n_err++;
            $display("FAIL shadow_zero_kernel: data=%h want 0", d); end
        handshake(0);
        p = rand_patch();
        accept_patch(p, 1'b1, kb, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== conv_ref(kb, p) || conv_kernel !== kb) begin n_err++;
            $display("FAIL shadow_same_cycle: data=%h want %h", d, conv_ref(kb, p)); end
        handshake(0);
    endtask

    task automatic test_random();
        logic [KW-1:0] k; logic [IW-1:0] p; logic [OW-1:0] d, e; logic [31:0] idx; int rc; bit ok, wc;
        for (int it = 0; it < 12; it++) begin
            wc = 1'b0; k = '0;
            if ($urandom_range(0, 1) == 1) begin
                k = rand_kernel();
                if ($urandom_range(0, 1) == 1) wc = 1'b1; else write_kernel(k);
            end
            p = rand_patch();
            g_lat = $urandom_range(0, 10);
            g_stale = 1'($urandom_range(0, 1));
            accept_patch(p, wc, k, rc, ok);
            e = conv_ref(exp_shadow, p);
            wait_result(d, idx, ok);
            n_cmp++; if (!ok || d !== e || idx !== 32'(exp_idx) || rc != RSTC || err_timeout !== 1'b0) begin n_err++;
                $display("FAIL random%0d: data=%h idx=%0d rst=%0d err=%b want %h / %0d / %0d / 0",
                         it, d, idx, rc, err_timeout, e, exp_idx, RSTC); end
            handshake($urandom_range(0, 3));
        end
        g_stale = 0;
    endtask

    task automatic test_timeout();
`ifdef CONV_SCHED_TIMEOUT_EN
        logic [IW-1:0] p; logic [OW-1:0] d; logic [31:0] idx; int rc, n; bit ok;
        g_hang = 1; p = rand_patch();
        accept_patch(p, 1'b0, '0, rc, ok);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (n != TO || err_timeout !== 1'b1) begin n_err++;
            $display("FAIL timeout_trigger: run_cycles=%0d err=%b want %0d / 1", n, err_timeout, TO); end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== '0 || out_patch_idx !== 32'(exp_idx)) begin n_err++;
            $display("FAIL timeout_output: valid=%b data=%h idx=%0d want 1 / 0 / %0d", out_valid, out_data, out_patch_idx, exp_idx); end
        handshake(0);
        g_hang = 0; g_lat = 2; p = rand_patch();
        accept_patch(p, 1'b0, '0, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== conv_ref(exp_shadow, p) || err_timeout !== 1'b1) begin n_err++;
            $display("FAIL timeout_sticky: data=%h err=%b want %h / 1", d, err_timeout, conv_ref(exp_shadow, p)); end
        handshake(0);
`endif
    endtask

    task automatic test_reset_mid_run();
        logic [IW-1:0] p; logic [OW-1:0] d; logic [31:0] idx; int rc; bit ok;
        write_kernel(rand_kernel());
        p = fill_patch(1); g_lat = 30;
        accept_patch(p, 1'b0, '0, rc, ok);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || conv_reset !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++;
            $display("FAIL midreset_state: valid=%b conv_reset=%b in_ready=%b busy=%b want 0/1/1/0",
                     out_valid, conv_reset, in_ready, busy); end
        n_cmp++; if (conv_kernel !== '0 || out_patch_idx !== 32'd0 || err_timeout !== 1'b0) begin n_err++;
            $display("FAIL midreset_regs: kernel=%h idx=%0d err=%b want 0", conv_kernel, out_patch_idx, err_timeout); end
        reset = 1'b1; exp_shadow = '0; exp_idx = 1; g_lat = 2;
        @(negedge clk);
        accept_patch(p, 1'b0, '0, rc, ok);
        wait_result(d, idx, ok);
        n_cmp++; if (!ok || d !== '0 || idx !== 32'd1) begin n_err++;
            $display("FAIL midreset_next: data=%h idx=%0d want 0 / 1", d, idx); end
        handshake(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_kernel_shadow();
        test_random();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
